// File: rtl/xpu.sv
// rtl/xpu.sv - reduced lower-MAC processing unit: AXI4-Lite register file, RX header parser, frame filter, TSF timer
//
// Ports
//   s00_axi_*                 AXI4-Lite slave, 32 word registers, word index = addr[6:2]
//   demod_is_ongoing          PHY demodulation in progress (mirrored to demod_is_ongoing_led)
//   pkt_header_valid(_strobe) SIGNAL field decoded; the strobe starts a new frame
//   pkt_rate, pkt_len         latched on the header strobe
//   byte_in_strobe/byte_in/byte_count  MPDU byte stream with byte index
//   fcs_in_strobe, fcs_ok     end of frame and CRC result
//   mac_addr                  this node's address {slv_reg31[15:0], slv_reg30}
//   FC_DI, addr1..3 (+_valid) parsed header fields, valids pulse once per field
//   pkt_for_me                addr1 matches mac_addr or broadcast
//   block_rx_dma_to_ps(_valid) drop decision for the RX DMA path
//   tsf_runtime_val, tsf_pulse_1M  1 us timestamp counter and its tick
//
// Optional build macro XPU_TSF_LOAD_EN: word 0x20 stages the low TSF word and a
// write to 0x24 loads {wdata, staging} into the TSF counter and clears the divider.
module xpu #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 8,
    parameter int TSF_TIMER_WIDTH      = 64,
    parameter int TSF_CLK_DIV          = 100
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              demod_is_ongoing,
    input  logic                              pkt_header_valid,
    input  logic                              pkt_header_valid_strobe,
    input  logic [7:0]                        pkt_rate,
    input  logic [15:0]                       pkt_len,
    input  logic                              byte_in_strobe,
    input  logic [7:0]                        byte_in,
    input  logic [15:0]                       byte_count,
    input  logic                              fcs_in_strobe,
    input  logic                              fcs_ok,
    output logic [47:0]                       mac_addr,
    output logic [31:0]                       FC_DI,
    output logic                              FC_DI_valid,
    output logic [47:0]                       addr1,
    output logic                              addr1_valid,
    output logic [47:0]                       addr2,
    output logic                              addr2_valid,
    output logic [47:0]                       addr3,
    output logic                              addr3_valid,
    output logic                              pkt_for_me,
    output logic                              block_rx_dma_to_ps,
    output logic                              block_rx_dma_to_ps_valid,
    output logic                              demod_is_ongoing_led,
    output logic                              sig_valid_led,
    output logic [TSF_TIMER_WIDTH-1:0]        tsf_runtime_val,
    output logic                              tsf_pulse_1M
);

    localparam int NREG  = 32;
    localparam int HDR_N = 22;
    localparam int DIV_W = (TSF_CLK_DIV > 1) ? $clog2(TSF_CLK_DIV) : 1;

    localparam logic [4:0] IDX_TSF_STAGE = 5'd8;
    localparam logic [4:0] IDX_TSF_LOAD  = 5'd9;
    localparam logic [4:0] IDX_TSF_LO    = 5'd24;
    localparam logic [4:0] IDX_TSF_HI    = 5'd25;
    localparam logic [4:0] IDX_FILTER    = 5'd27;
    localparam logic [4:0] IDX_MAC_LO    = 5'd30;
    localparam logic [4:0] IDX_MAC_HI    = 5'd31;

    // AXI state
    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        bvalid_q, bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] slv_reg_q [NREG];
    logic [31:0] slv_reg_d [NREG];

    // RX header state
    logic [15:0] pkt_len_q, pkt_len_d;
    logic [7:0]  pkt_rate_q, pkt_rate_d;
    logic [7:0]  hdr_q [HDR_N];
    logic [7:0]  hdr_d [HDR_N];
    logic        fc_valid_q, fc_valid_d;
    logic        a1_valid_q, a1_valid_d;
    logic        a2_valid_q, a2_valid_d;
    logic        a3_valid_q, a3_valid_d;
    logic        for_me_q, for_me_d;
    logic        block_q, block_d;
    logic        block_valid_q, block_valid_d;
    logic        decided_q, decided_d;
    logic        demod_led_q, demod_led_d;
    logic        sig_led_q, sig_led_d;

    // TSF state
    logic [TSF_TIMER_WIDTH-1:0] tsf_q, tsf_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       pulse_q, pulse_d;

    logic [4:0]  wr_idx;
    logic [4:0]  rd_idx;
    logic        wr_fire;
    logic        rd_fire;
    logic [31:0] wr_data_m;
    logic [31:0] rd_mux;
    logic [47:0] addr1_cand;
    logic        filter_on;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                r[i*8 +: 8] = new_v[i*8 +: 8];
            end
        end
        return r;
    endfunction

    assign wr_idx    = s00_axi_awaddr[6:2];
    assign rd_idx    = s00_axi_araddr[6:2];
    // Ready is only raised while both valids are up, so a held ready means handshake.
    assign wr_fire   = awready_q & wready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rd_fire   = arready_q & s00_axi_arvalid;
    assign wr_data_m = apply_strb(slv_reg_q[wr_idx], s00_axi_wdata, s00_axi_wstrb);
    assign filter_on = slv_reg_q[IDX_FILTER][0];

    // addr1 as it will be once the byte being presented now (n = 9) is stored
    assign addr1_cand = {byte_in, hdr_q[8], hdr_q[7], hdr_q[6], hdr_q[5], hdr_q[4]};

    always_comb begin
        rd_mux = slv_reg_q[rd_idx];
        if (rd_idx == IDX_TSF_LO) begin
            rd_mux = tsf_q[31:0];
        end else if (rd_idx == IDX_TSF_HI) begin
            rd_mux = tsf_q[63:32];
        end
    end

    always_comb begin
        awready_d     = 1'b0;
        wready_d      = 1'b0;
        bvalid_d      = bvalid_q;
        arready_d     = 1'b0;
        rvalid_d      = rvalid_q;
        rdata_d       = rdata_q;
        slv_reg_d     = slv_reg_q;
        pkt_len_d     = pkt_len_q;
        pkt_rate_d    = pkt_rate_q;
        hdr_d         = hdr_q;
        fc_valid_d    = 1'b0;
        a1_valid_d    = 1'b0;
        a2_valid_d    = 1'b0;
        a3_valid_d    = 1'b0;
        for_me_d      = for_me_q;
        block_d       = block_q;
        block_valid_d = 1'b0;
        decided_d     = decided_q;
        demod_led_d   = demod_is_ongoing;
        sig_led_d     = sig_led_q;
        tsf_d         = tsf_q;
        div_d         = div_q;
        pulse_d       = 1'b0;

        // AXI write channel
        if (!awready_q && s00_axi_awvalid && s00_axi_wvalid && !bvalid_q) begin
            awready_d = 1'b1;
            wready_d  = 1'b1;
        end
        if (wr_fire) begin
            if (wr_idx != IDX_TSF_LO && wr_idx != IDX_TSF_HI) begin
                slv_reg_d[wr_idx] = wr_data_m;
            end
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d = 1'b0;
        end

        // AXI read channel
        if (!arready_q && s00_axi_arvalid && !rvalid_q) begin
            arready_d = 1'b1;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_mux;
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        // TSF divider and counter
        if (div_q == DIV_W'(TSF_CLK_DIV - 1)) begin
            div_d   = '0;
            pulse_d = 1'b1;
            tsf_d   = tsf_q + 1'b1;
        end else begin
            div_d   = div_q + 1'b1;
        end
`ifdef XPU_TSF_LOAD_EN
        if (wr_fire && wr_idx == IDX_TSF_LOAD) begin
            tsf_d   = TSF_TIMER_WIDTH'({wr_data_m, slv_reg_q[IDX_TSF_STAGE]});
            div_d   = '0;
            pulse_d = 1'b0;
        end
`endif

        // RX header parsing; a new header strobe overrides any byte in the same cycle
        if (pkt_header_valid_strobe) begin
            pkt_len_d  = pkt_len;
            pkt_rate_d = pkt_rate;
            for_me_d   = 1'b0;
            block_d    = 1'b0;
            decided_d  = 1'b0;
            sig_led_d  = ~sig_led_q;
        end else begin
            if (byte_in_strobe && byte_count < 16'(HDR_N)) begin
                hdr_d[byte_count[4:0]] = byte_in;
                fc_valid_d = (byte_count == 16'd3);
                a1_valid_d = (byte_count == 16'd9);
                a2_valid_d = (byte_count == 16'd15);
                a3_valid_d = (byte_count == 16'd21);
                if (byte_count == 16'd9) begin
                    for_me_d  = (addr1_cand == mac_addr) || (addr1_cand == 48'hFFFF_FFFF_FFFF);
                    decided_d = 1'b1;
                end
            end
            if (a1_valid_q) begin
                block_d       = filter_on & ~for_me_q;
                block_valid_d = 1'b1;
            end
            // Frame ended before addr1 was known: fall back to the filter setting alone
            if (fcs_in_strobe && !decided_q) begin
                block_d       = filter_on;
                block_valid_d = 1'b1;
                decided_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            for (int i = 0; i < NREG; i++) begin
                slv_reg_q[i] <= '0;
            end
            pkt_len_q     <= '0;
            pkt_rate_q    <= '0;
            for (int i = 0; i < HDR_N; i++) begin
                hdr_q[i] <= '0;
            end
            fc_valid_q    <= 1'b0;
            a1_valid_q    <= 1'b0;
            a2_valid_q    <= 1'b0;
            a3_valid_q    <= 1'b0;
            for_me_q      <= 1'b0;
            block_q       <= 1'b0;
            block_valid_q <= 1'b0;
            decided_q     <= 1'b0;
            demod_led_q   <= 1'b0;
            sig_led_q     <= 1'b0;
            tsf_q         <= '0;
            div_q         <= '0;
            pulse_q       <= 1'b0;
        end else begin
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            slv_reg_q     <= slv_reg_d;
            pkt_len_q     <= pkt_len_d;
            pkt_rate_q    <= pkt_rate_d;
            hdr_q         <= hdr_d;
            fc_valid_q    <= fc_valid_d;
            a1_valid_q    <= a1_valid_d;
            a2_valid_q    <= a2_valid_d;
            a3_valid_q    <= a3_valid_d;
            for_me_q      <= for_me_d;
            block_q       <= block_d;
            block_valid_q <= block_valid_d;
            decided_q     <= decided_d;
            demod_led_q   <= demod_led_d;
            sig_led_q     <= sig_led_d;
            tsf_q         <= tsf_d;
            div_q         <= div_d;
            pulse_q       <= pulse_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;

    assign mac_addr    = {slv_reg_q[IDX_MAC_HI][15:0], slv_reg_q[IDX_MAC_LO]};
    assign FC_DI       = {hdr_q[3], hdr_q[2], hdr_q[1], hdr_q[0]};
    assign addr1       = {hdr_q[9], hdr_q[8], hdr_q[7], hdr_q[6], hdr_q[5], hdr_q[4]};
    assign addr2       = {hdr_q[15], hdr_q[14], hdr_q[13], hdr_q[12], hdr_q[11], hdr_q[10]};
    assign addr3       = {hdr_q[21], hdr_q[20], hdr_q[19], hdr_q[18], hdr_q[17], hdr_q[16]};
    assign FC_DI_valid = fc_valid_q;
    assign addr1_valid = a1_valid_q;
    assign addr2_valid = a2_valid_q;
    assign addr3_valid = a3_valid_q;
    assign pkt_for_me  = for_me_q;
    assign block_rx_dma_to_ps       = block_q;
    assign block_rx_dma_to_ps_valid = block_valid_q;
    assign demod_is_ongoing_led     = demod_led_q;
    assign sig_valid_led            = sig_led_q;
    assign tsf_runtime_val          = tsf_q;
    assign tsf_pulse_1M             = pulse_q;

    // Inputs and latched fields that no local logic consumes
    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr,
                         pkt_header_valid, fcs_ok, pkt_len_q, pkt_rate_q};

endmodule

// File: tb/tb_xpu.sv
// tb/tb_xpu.sv - self-checking testbench for xpu
module tb_xpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        demod_is_ongoing, pkt_header_valid, pkt_header_valid_strobe;
    logic [7:0]  pkt_rate, byte_in;
    logic [15:0] pkt_len, byte_count;
    logic        byte_in_strobe, fcs_in_strobe, fcs_ok;
    logic [47:0] mac_addr, addr1, addr2, addr3;
    logic [31:0] FC_DI;
    logic        FC_DI_valid, addr1_valid, addr2_valid, addr3_valid, pkt_for_me;
    logic        block_rx_dma_to_ps, block_rx_dma_to_ps_valid;
    logic        demod_is_ongoing_led, sig_valid_led, tsf_pulse_1M;
    logic [63:0] tsf_runtime_val;

    always #5 clk = ~clk;

    xpu dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready), .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid), .s00_axi_wready(wready), .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid), .s00_axi_bready(bready), .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready), .demod_is_ongoing(demod_is_ongoing),
        .pkt_header_valid(pkt_header_valid), .pkt_header_valid_strobe(pkt_header_valid_strobe),
        .pkt_rate(pkt_rate), .pkt_len(pkt_len), .byte_in_strobe(byte_in_strobe),
        .byte_in(byte_in), .byte_count(byte_count), .fcs_in_strobe(fcs_in_strobe),
        .fcs_ok(fcs_ok), .mac_addr(mac_addr), .FC_DI(FC_DI), .FC_DI_valid(FC_DI_valid),
        .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr1_valid(addr1_valid),
        .addr2_valid(addr2_valid), .addr3_valid(addr3_valid), .pkt_for_me(pkt_for_me),
        .block_rx_dma_to_ps(block_rx_dma_to_ps), .block_rx_dma_to_ps_valid(block_rx_dma_to_ps_valid),
        .demod_is_ongoing_led(demod_is_ongoing_led), .sig_valid_led(sig_valid_led),
        .tsf_runtime_val(tsf_runtime_val), .tsf_pulse_1M(tsf_pulse_1M)
    );

    int total = 0;
    int bad = 0;
    int unsigned cyc;
    logic [31:0] reg_m [32];
    int          hdr_strobes;

    // frame stimulus and observations
    logic [7:0]  fb [32];
    int          cnt_fc, cnt_a1, cnt_a2, cnt_a3, cnt_blk;
    logic [31:0] val_fc;
    logic [47:0] val_a1, val_a2, val_a3;
    logic        fm_at_a1, blk_at;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic idle_inputs();
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        demod_is_ongoing = 0; pkt_header_valid = 0; pkt_header_valid_strobe = 0;
        pkt_rate = 0; pkt_len = 0; byte_in_strobe = 0; byte_in = 0; byte_count = 0;
        fcs_in_strobe = 0; fcs_ok = 0;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 32; i++) reg_m[i] = 0;
        hdr_strobes = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        clear_models();
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [47:0] fb_field(input int start);
        logic [47:0] v;
        v = 0;
        for (int i = 0; i < 6; i++) v[i*8 +: 8] = fb[start + i];
        return v;
    endfunction

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output bit ok, output logic [1:0] resp);
        bit seen;
        ok = 1; seen = 0; resp = 2'bxx;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (awready) begin
                seen = 1;
                if (wready !== 1'b1) ok = 0;
            end
        end
        if (!seen) ok = 0;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) ok = 0;
        resp = bresp;
        bready = 1;
        @(posedge clk); #1;
        bready = 0;
        @(negedge clk);
        if (bvalid !== 1'b0) ok = 0;
        if (a[6:2] != 24 && a[6:2] != 25) reg_m[a[6:2]] = merge(reg_m[a[6:2]], d, s);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit ok, output int unsigned e);
        bit seen;
        ok = 1; seen = 0; e = 0; d = 'x; resp = 2'bxx;
        @(posedge clk); #1;
        araddr = a; arvalid = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (arready) begin seen = 1; e = cyc; end
        end
        if (!seen) ok = 0;
        @(posedge clk); #1;
        arvalid = 0;
        @(negedge clk);
        if (rvalid !== 1'b1 || arready !== 1'b0) ok = 0;
        d = rdata; resp = rresp;
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
        @(negedge clk);
        if (rvalid !== 1'b0) ok = 0;
    endtask

    task automatic send_frame(input int nb, input bit fcs_end, input bit gaps);
        int i, tail;
        cnt_fc = 0; cnt_a1 = 0; cnt_a2 = 0; cnt_a3 = 0; cnt_blk = 0;
        val_fc = 'x; val_a1 = 'x; val_a2 = 'x; val_a3 = 'x; fm_at_a1 = 1'bx; blk_at = 1'bx;
        @(posedge clk); #1;
        pkt_header_valid_strobe = 1; pkt_header_valid = 1; pkt_len = 64; pkt_rate = 8'h0B;
        demod_is_ongoing = 1;
        hdr_strobes++;
        i = 0; tail = 0;
        while (tail < 5) begin
            @(posedge clk); #1;
            pkt_header_valid_strobe = 0; byte_in_strobe = 0; fcs_in_strobe = 0;
            if (i < nb) begin
                if (!(gaps && $urandom_range(0, 3) == 0)) begin
                    byte_in_strobe = 1; byte_in = fb[i]; byte_count = 16'(i); i++;
                end
            end else begin
                if (tail == 0 && fcs_end) begin fcs_in_strobe = 1; fcs_ok = 1; end
                tail++;
            end
            @(negedge clk);
            if (FC_DI_valid) begin cnt_fc++; val_fc = FC_DI; end
            if (addr1_valid) begin cnt_a1++; val_a1 = addr1; fm_at_a1 = pkt_for_me; end
            if (addr2_valid) begin cnt_a2++; val_a2 = addr2; end
            if (addr3_valid) begin cnt_a3++; val_a3 = addr3; end
            if (block_rx_dma_to_ps_valid) begin cnt_blk++; blk_at = block_rx_dma_to_ps; end
        end
        @(posedge clk); #1;
        byte_in_strobe = 0; fcs_in_strobe = 0; fcs_ok = 0; demod_is_ongoing = 0; pkt_header_valid = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        clear_models();
        #100;
        total++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, mac_addr, FC_DI,
             FC_DI_valid, addr1, addr2, addr3, addr1_valid, addr2_valid, addr3_valid, pkt_for_me,
             block_rx_dma_to_ps, block_rx_dma_to_ps_valid, demod_is_ongoing_led, sig_valid_led,
             tsf_runtime_val, tsf_pulse_1M} !== '0) begin
            bad++; $display("FAIL reset_outputs: some output nonzero (tsf=%0h mac=%0h)", tsf_runtime_val, mac_addr);
        end
        @(posedge clk); #1 rst_n = 1;
        @(negedge clk);
        total++;
        if (tsf_runtime_val !== 64'd0 || tsf_pulse_1M !== 1'b0 || bvalid !== 1'b0 || rvalid !== 1'b0) begin
            bad++; $display("FAIL reset_release: tsf=%0h pulse=%b bvalid=%b rvalid=%b want 0", tsf_runtime_val, tsf_pulse_1M, bvalid, rvalid);
        end
    endtask

    task automatic test_tsf();
        int bad_pulse, pulses;
        bad_pulse = 0; pulses = 0;
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            @(posedge clk); @(negedge clk);
            if (tsf_pulse_1M) pulses++;
            if (tsf_pulse_1M !== ((cyc % 100) == 0)) bad_pulse++;
            if (tsf_runtime_val !== 64'(cyc / 100)) bad_pulse++;
        end
        total++;
        if (bad_pulse != 0) begin bad++; $display("FAIL tsf_timing: %0d cycles off, want 0", bad_pulse); end
        total++;
        if (pulses != 10 || tsf_runtime_val !== 64'd10) begin
            bad++; $display("FAIL tsf_1000: pulses=%0d tsf=%0d want 10/10", pulses, tsf_runtime_val);
        end
    endtask

    task automatic test_mac_regs();
        bit ok; logic [1:0] resp; logic [31:0] d; int unsigned e;
        axi_write(8'h78, 32'hDDCCBBAA, 4'hF, ok, resp);
        total++;
        if (ok !== 1'b1 || resp !== 2'b00) begin bad++; $display("FAIL write_78: hs_ok=%b bresp=%0d want 1/0", ok, resp); end
        axi_write(8'h7C, 32'h0000FFEE, 4'hF, ok, resp);
        total++;
        if (ok !== 1'b1 || resp !== 2'b00) begin bad++; $display("FAIL write_7c: hs_ok=%b bresp=%0d want 1/0", ok, resp); end
        total++;
        if (mac_addr !== 48'hFFEEDDCCBBAA) begin bad++; $display("FAIL mac_addr: got %h want ffeeddccbbaa", mac_addr); end
        axi_write(8'h6C, 32'h1, 4'hF, ok, resp);
        axi_read(8'h6C, d, resp, ok, e);
        total++;
        if (ok !== 1'b1 || d !== 32'h1 || resp !== 2'b00) begin
            bad++; $display("FAIL read_6c: hs_ok=%b rdata=%h rresp=%0d want 1/00000001/0", ok, d, resp);
        end
    endtask

    task automatic test_directed_frames();
        logic [7:0] base [24];
        logic [47:0] a1_tab [4];
        logic [3:0]  filt_tab, fm_tab, blk_tab;
        bit ok; logic [1:0] resp;
        base = '{8'h08, 8'h01, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22,
                 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
        a1_tab = '{48'hFFEEDDCCBBAA, 48'h060504030201, 48'h060504030201, 48'hFFFFFFFFFFFF};
        filt_tab = 4'b1011;   // index 0 in bit 0
        fm_tab   = 4'b1001;
        blk_tab  = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            axi_write(8'h6C, {31'd0, filt_tab[c]}, 4'hF, ok, resp);
            for (int i = 0; i < 24; i++) fb[i] = base[i];
            for (int i = 0; i < 6; i++) fb[4 + i] = a1_tab[c][i*8 +: 8];
            send_frame(24, 1'b1, 1'b0);
            total++;
            if (cnt_fc != 1 || val_fc !== 32'h00000108) begin
                bad++; $display("FAIL dir%0d_fc: count=%0d FC_DI=%h want 1/00000108", c, cnt_fc, val_fc);
            end
            total++;
            if (cnt_a1 != 1 || val_a1 !== a1_tab[c] || cnt_a2 != 1 || val_a2 !== 48'h665544332211 ||
                cnt_a3 != 1 || val_a3 !== 48'hCCBBAA998877) begin
                bad++; $display("FAIL dir%0d_addr: n=%0d/%0d/%0d a1=%h a2=%h a3=%h want 1/1/1 %h 665544332211 ccbbaa998877",
                                c, cnt_a1, cnt_a2, cnt_a3, val_a1, val_a2, val_a3, a1_tab[c]);
            end
            total++;
            if (fm_at_a1 !== fm_tab[c] || pkt_for_me !== fm_tab[c]) begin
                bad++; $display("FAIL dir%0d_for_me: at_valid=%b final=%b want %b", c, fm_at_a1, pkt_for_me, fm_tab[c]);
            end
            total++;
            if (cnt_blk != 1 || blk_at !== blk_tab[c] || block_rx_dma_to_ps !== blk_tab[c]) begin
                bad++; $display("FAIL dir%0d_block: count=%0d block=%b want 1/%b", c, cnt_blk, blk_at, blk_tab[c]);
            end
        end
    endtask

    task automatic test_random_regs();
        bit ok; logic [1:0] resp; logic [31:0] d, v; logic [3:0] s; int unsigned e;
        logic [4:0] idx;
        int errs;
        errs = 0;
        for (int n = 0; n < 30; n++) begin
            do idx = 5'($urandom_range(0, 31));
            while (idx == 8 || idx == 9 || idx == 24 || idx == 25);
            v = $urandom; s = 4'($urandom_range(0, 15));
            axi_write({1'b0, idx, 2'b00}, v, s, ok, resp);
            if (!ok || resp !== 2'b00) errs++;
            axi_read({1'b0, idx, 2'b00}, d, resp, ok, e);
            if (!ok || d !== reg_m[idx] || resp !== 2'b00) begin
                errs++; $display("FAIL reg_rw[%0d]: got %h want %h", idx, d, reg_m[idx]);
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_regs: %0d errors want 0", errs); end
        total++;
        if (mac_addr !== {reg_m[31][15:0], reg_m[30]}) begin
            bad++; $display("FAIL mac_after_random: got %h want %h", mac_addr, {reg_m[31][15:0], reg_m[30]});
        end
    endtask

    task automatic test_random_frames();
        bit ok; logic [1:0] resp;
        logic [47:0] mac_m, a1_m;
        logic filt, exp_fm, exp_blk;
        int nb, sel, errs;
        bit short_f, fcs_end;
        errs = 0;
        for (int f = 0; f < 25; f++) begin
            axi_write(8'h6C, $urandom, 4'($urandom_range(0, 15)), ok, resp);
            mac_m = {reg_m[31][15:0], reg_m[30]};
            filt = reg_m[27][0];
            for (int i = 0; i < 32; i++) fb[i] = 8'($urandom);
            sel = $urandom_range(0, 2);
            a1_m = (sel == 0) ? mac_m : (sel == 1) ? 48'hFFFFFFFFFFFF : {$urandom, $urandom} ;
            for (int i = 0; i < 6; i++) fb[4 + i] = a1_m[i*8 +: 8];
            short_f = ($urandom_range(0, 4) == 0);
            nb = short_f ? $urandom_range(1, 9) : $urandom_range(22, 28);
            fcs_end = short_f ? 1'b1 : 1'($urandom_range(0, 1));
            send_frame(nb, fcs_end, 1'b1);
            exp_fm  = (nb >= 10) && (a1_m == mac_m || a1_m == 48'hFFFFFFFFFFFF);
            exp_blk = (nb >= 10) ? (filt & ~exp_fm) : filt;
            if (cnt_fc != (nb >= 4 ? 1 : 0) || (nb >= 4 && val_fc !== {fb[3], fb[2], fb[1], fb[0]})) begin
                errs++; $display("FAIL rnd%0d_fc: n=%0d FC_DI=%h nb=%0d", f, cnt_fc, val_fc, nb);
            end
            if (cnt_a1 != (nb >= 10 ? 1 : 0) || (nb >= 10 && (val_a1 !== fb_field(4) || fm_at_a1 !== exp_fm))) begin
                errs++; $display("FAIL rnd%0d_a1: n=%0d a1=%h fm=%b want %h/%b", f, cnt_a1, val_a1, fm_at_a1, fb_field(4), exp_fm);
            end
            if (cnt_a2 != (nb >= 16 ? 1 : 0) || (nb >= 16 && val_a2 !== fb_field(10))) begin
                errs++; $display("FAIL rnd%0d_a2: n=%0d a2=%h want %h", f, cnt_a2, val_a2, fb_field(10));
            end
            if (cnt_a3 != (nb >= 22 ? 1 : 0) || (nb >= 22 && (val_a3 !== fb_field(16) || addr3 !== fb_field(16)))) begin
                errs++; $display("FAIL rnd%0d_a3: n=%0d a3=%h final=%h want %h", f, cnt_a3, val_a3, addr3, fb_field(16));
            end
            if (cnt_blk != 1 || blk_at !== exp_blk || block_rx_dma_to_ps !== exp_blk || pkt_for_me !== exp_fm) begin
                errs++; $display("FAIL rnd%0d_block: n=%0d block=%b fm=%b want 1/%b/%b", f, cnt_blk, blk_at, pkt_for_me, exp_blk, exp_fm);
            end
            if (sig_valid_led !== 1'(hdr_strobes % 2)) begin
                errs++; $display("FAIL rnd%0d_led: sig_valid_led=%b want %b", f, sig_valid_led, 1'(hdr_strobes % 2));
            end
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL random_frames: %0d errors want 0", errs); end
    endtask

    task automatic test_strobe_priority();
        logic led_before;
        led_before = sig_valid_led;
        @(posedge clk); #1;
        pkt_header_valid_strobe = 1; byte_in_strobe = 1; byte_count = 3; byte_in = 8'h5A;
        demod_is_ongoing = 1;
        @(posedge clk); #1;
        pkt_header_valid_strobe = 0; byte_in_strobe = 0;
        @(negedge clk);
        total++;
        if (FC_DI_valid !== 1'b0 || sig_valid_led !== ~led_before || demod_is_ongoing_led !== 1'b1) begin
            bad++; $display("FAIL strobe_priority: FC_DI_valid=%b led=%b demod_led=%b want 0/%b/1",
                            FC_DI_valid, sig_valid_led, demod_is_ongoing_led, ~led_before);
        end
        hdr_strobes++;
        demod_is_ongoing = 0;
    endtask

    task automatic test_tsf_regs();
        bit ok; logic [1:0] resp; logic [31:0] d; int unsigned e;
        axi_write(8'h60, 32'hFFFFFFFF, 4'hF, ok, resp);
        axi_write(8'h64, 32'hFFFFFFFF, 4'hF, ok, resp);
        axi_read(8'h60, d, resp, ok, e);
        total++;
        if (!ok || d !== 32'(e / 100)) begin bad++; $display("FAIL tsf_lo_read: got %0d want %0d", d, e / 100); end
        axi_read(8'h64, d, resp, ok, e);
        total++;
        if (!ok || d !== 32'd0) begin bad++; $display("FAIL tsf_hi_read: got %h want 0", d); end
    endtask

    task automatic test_tsf_load();
        bit ok; logic [1:0] resp; logic [31:0] d; int unsigned e;
        axi_write(8'h20, 32'd5, 4'hF, ok, resp);
        axi_write(8'h24, 32'd0, 4'hF, ok, resp);
        @(negedge clk);
        total++;
`ifdef XPU_TSF_LOAD_EN
        if (tsf_runtime_val !== 64'd5) begin bad++; $display("FAIL tsf_load: tsf=%0d want 5", tsf_runtime_val); end
`else
        if (tsf_runtime_val !== 64'(cyc / 100)) begin
            bad++; $display("FAIL tsf_noload: tsf=%0d want %0d", tsf_runtime_val, cyc / 100);
        end
`endif
        axi_read(8'h20, d, resp, ok, e);
        total++;
        if (!ok || d !== 32'd5) begin bad++; $display("FAIL stage_read: got %h want 5", d); end
        axi_read(8'h24, d, resp, ok, e);
        total++;
        if (!ok || d !== 32'd0) begin bad++; $display("FAIL load_hi_read: got %h want 0", d); end
    endtask

    task automatic test_reset_abort();
        bit ok; logic [1:0] resp; logic [31:0] d; int unsigned e;
        @(posedge clk); #1;
        pkt_header_valid_strobe = 1; demod_is_ongoing = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pkt_header_valid_strobe = 0; byte_in_strobe = 1; byte_count = 16'(i); byte_in = 8'hFF;
        end
        awaddr = 8'h78; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        total++;
        if ({awready, wready, bvalid, mac_addr, FC_DI, FC_DI_valid, addr1, pkt_for_me,
             block_rx_dma_to_ps, demod_is_ongoing_led, sig_valid_led, tsf_runtime_val} !== '0) begin
            bad++; $display("FAIL reset_abort: outputs not cleared (mac=%h fc=%h tsf=%0h)", mac_addr, FC_DI, tsf_runtime_val);
        end
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        clear_models();
        axi_read(8'h78, d, resp, ok, e);
        total++;
        if (!ok || d !== 32'd0) begin bad++; $display("FAIL reset_abort_reg: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_tsf();
        test_mac_regs();
        test_directed_frames();
        test_strobe_priority();
        test_random_regs();
        test_random_frames();
        test_tsf_regs();
        test_reset_abort();
        test_tsf_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/xpu.md
Name: xpu

Overview:
- Reduced lower-MAC "xpu" processing unit.
- Holds an AXI4-Lite register file: MAC address, packet filter enable, CSMA/ACK timing words.
- Parses received 802.11 MAC header bytes from the PHY (frame control, addr1-3) and decides whether the frame is for this node.
- Tells the RX DMA path to drop frames when filtering is on; runs a 1 µs TSF timer.

Parameters:
- C_S00_AXI_DATA_WIDTH, 32, AXI data width (fixed at 32).
- C_S00_AXI_ADDR_WIDTH, 8, AXI byte address width; word index = addr[6:2].
- TSF_TIMER_WIDTH, 64, TSF counter width.
- TSF_CLK_DIV, 100, clock cycles per µs.

Ports:
- s00_axi_aclk in 1: sole clock.
- s00_axi_aresetn in 1: async active-low reset.
- s00_axi_aw{addr,prot,valid}/awready, w{data,strb,valid}/wready, bresp/bvalid/bready, ar{addr,prot,valid}/arready, rdata/rresp/rvalid/rready: AXI4-Lite slave, standard widths.
- demod_is_ongoing in 1: PHY demodulating.
- pkt_header_valid in 1, pkt_header_valid_strobe in 1: SIGNAL field decoded; the strobe starts a new frame.
- pkt_rate in 8, pkt_len in 16: latched on the strobe.
- byte_in_strobe in 1, byte_in in 8, byte_count in 16: MPDU byte stream with byte index.
- fcs_in_strobe in 1, fcs_ok in 1: frame end and CRC result.
- mac_addr out 48, FC_DI out 32, FC_DI_valid out 1.
- addr1/addr2/addr3 out 48, addr1_valid/addr2_valid/addr3_valid out 1.
- pkt_for_me out 1.
- block_rx_dma_to_ps out 1, block_rx_dma_to_ps_valid out 1.
- demod_is_ongoing_led out 1, sig_valid_led out 1.
- tsf_runtime_val out 64, tsf_pulse_1M out 1.

Behaviour:
- Reset: all registers and outputs are 0, all AXI ready/valid signals are 0, bresp/rresp = 0.
- AXI write:
  - awready and wready pulse together for 1 cycle once awvalid and wvalid are both high and no response is pending.
  - The register updates in that cycle, honouring wstrb per byte.
  - bvalid rises the next cycle and holds until bready.
- AXI read:
  - arready pulses for 1 cycle.
  - rvalid rises the next cycle with rdata and holds until rready.
- Register map: 32 read/write words slv_reg0..31.
  - 0x18: CSMA disable bits (stored only).
  - 0x40, 0x48: ACK timing words (stored only).
  - 0x6C bit0: filter_on.
  - 0x78: mac_addr[31:0].
  - 0x7C bits[15:0]: mac_addr[47:32].
  - 0x60/0x64 read back tsf_runtime_val low/high; writes to them are ignored.
- mac_addr is combinational from slv_reg31[15:0] and slv_reg30.
- pkt_header_valid_strobe:
  - latches pkt_len and pkt_rate;
  - clears all *_valid outputs, pkt_for_me and block_rx_dma_to_ps;
  - the strobe wins over any simultaneous byte strobe.
- Header capture: on byte_in_strobe, byte_count n stores byte_in at header byte n (little-endian).
  - FC_DI = {b3,b2,b1,b0}.
  - addr1 = {b9..b4}, addr2 = {b15..b10}, addr3 = {b21..b16}.
  - Each valid pulses for exactly 1 cycle, the cycle after its last byte (n = 3, 9, 15, 21).
  - Bytes with n >= 22 are ignored.
- pkt_for_me: registered together with addr1_valid; 1 when addr1 == mac_addr or addr1 == 48'hFFFFFFFFFFFF. Holds until the next header strobe.
- Filter decision:
  - One cycle after addr1_valid: block_rx_dma_to_ps = filter_on & ~pkt_for_me, and block_rx_dma_to_ps_valid pulses for 1 cycle.
  - block_rx_dma_to_ps holds until the next header strobe.
- Short frame: fcs_in_strobe before addr1 is complete forces block_rx_dma_to_ps = filter_on and pulses block_rx_dma_to_ps_valid.
- LEDs (registered):
  - demod_is_ongoing_led = demod_is_ongoing.
  - sig_valid_led toggles on each pkt_header_valid_strobe.
- TSF: a divider counts 0..TSF_CLK_DIV-1; tsf_pulse_1M is high for 1 cycle at wrap; tsf_runtime_val increments on the pulse and wraps modulo 2^64.
- Reset asserted mid-frame or mid-AXI-transaction aborts it immediately; outputs return to reset values.

Optional Feature:
- Macro XPU_TSF_LOAD_EN.
- Defined:
  - writing 0x20 stores a staging low word;
  - writing 0x24 loads tsf_runtime_val = {wdata, staging} and clears the divider;
  - 0x20/0x24 read back the staging low word and last high word written.
- Undefined: 0x20/0x24 are plain storage; TSF is never loaded.

Test Plan:
- Reset 100 ns, then write 0x78 = 0xDDCCBBAA and 0x7C = 0x0000FFEE -> each write gets one awready/wready pulse, then bvalid, bresp = 0; mac_addr = 48'hFFEEDDCCBBAA.
- Write 0x6C = 1, read 0x6C -> rdata = 0x00000001, rresp = 0.
- Header strobe with pkt_len = 64, rate 0x0B, then bytes 08 01 00 00 AA BB CC DD EE FF 11 22 33 44 55 66 77 88 99 AA BB CC 00 00 -> FC_DI = 0x00000108; addr1 = 0xFFEEDDCCBBAA, addr2 = 0x665544332211, addr3 = 0xCCBBAA998877, each valid 1 cycle; pkt_for_me = 1; block_rx_dma_to_ps_valid pulse with block = 0.
- Same frame with addr1 = 01:02:03:04:05:06 and filter_on = 1 -> pkt_for_me = 0, block = 1; with filter_on = 0 -> block = 0.
- Broadcast addr1, filter_on = 1 -> pkt_for_me = 1, block = 0.
- Run 1000 cycles after reset -> tsf_pulse_1M every 100 cycles, tsf_runtime_val = 10. With XPU_TSF_LOAD_EN defined, write 0x20 = 5 then 0x24 = 0 -> tsf_runtime_val = 5.
